// File: rtl/pong_pkg.sv
// Shared geometry, state encodings and game-state record for the pong frame sequencer.
package pong_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PADDLE_H     = 64;
  localparam int PAD_W        = 8;
  localparam int LEFT_PAD_X   = 16;
  localparam int RIGHT_PAD_X  = 616;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_STEP  = 4;
  localparam int BALL_STEP    = 2;
  localparam int SCORE_MAX    = 9;
  localparam int SERVE_FRAMES = 60;

  localparam logic [8:0] PAD_MAX    = 9'(V_ACTIVE - PADDLE_H);
  localparam logic [8:0] PAD_INIT   = 9'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [8:0] PAD_STEP   = 9'(PADDLE_STEP);
  localparam logic [9:0] BALL_X0    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [8:0] BALL_Y0    = 9'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_X_MAX = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [8:0] BALL_Y_MAX = 9'(V_ACTIVE - BALL_SIZE);
  // Ball x positions after bouncing off the left / right paddle faces.
  localparam logic [9:0] L_FACE_X   = 10'(LEFT_PAD_X + PAD_W);
  localparam logic [9:0] R_FACE_X   = 10'(RIGHT_PAD_X - BALL_SIZE);
  localparam logic [9:0] R_PAD_END  = 10'(RIGHT_PAD_X + PAD_W);
  localparam logic [5:0] SERVE_INIT = 6'(SERVE_FRAMES);
  localparam logic [3:0] SCORE_TOP  = 4'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_WAIT, S_PADDLE, S_SERVE, S_BALL, S_HIT, S_SCORE, S_OVER
  } state_t;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  typedef struct packed {
    logic [8:0] pad_l;
    logic [8:0] pad_r;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    dir_t       dx;
    dir_t       dy;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [5:0] serve_cnt;
    logic       serving;
    logic       game_over;
  } game_t;

  localparam game_t GAME_INIT = '{
    pad_l: PAD_INIT, pad_r: PAD_INIT, ball_x: BALL_X0, ball_y: BALL_Y0,
    dx: DIR_POS, dy: DIR_POS, score_l: 4'd0, score_r: 4'd0,
    serve_cnt: SERVE_INIT, serving: 1'b1, game_over: 1'b0};

  // Pressing both buttons cancels out; movement saturates at the screen edges.
  function automatic logic [8:0] paddle_next(input logic [8:0] y, input logic up, input logic dn);
    paddle_next = y;
    if (up && !dn)
      paddle_next = (y >= PAD_STEP) ? y - PAD_STEP : 9'd0;
    else if (dn && !up)
      paddle_next = (y >= PAD_MAX - PAD_STEP) ? PAD_MAX : y + PAD_STEP;
  endfunction
endpackage

// File: rtl/pong_btn_sync.sv
// Two-flop synchroniser for the raw player buttons.
module btn_sync
  import pong_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] raw,
  output logic [NUM_LANES-1:0] sync
);
  logic [NUM_LANES-1:0] meta;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: on each frame_tick moves paddles, steps the ball, resolves hits and scoring.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  output logic [8:0] paddle_l_y,
  output logic [8:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serving,
  output logic       game_over,
  output logic       busy
);
  localparam logic signed [10:0] STEP_S = 11'(BALL_STEP);
  localparam logic signed [10:0] XMAX_S = 11'(BALL_X_MAX);
  localparam logic signed [10:0] YMAX_S = 11'(BALL_Y_MAX);

  state_t      state, state_nxt;
  game_t       g;
  logic        scorer_r;
  logic [3:0]  btn;
  logic signed [10:0] bx_n, by_n;
  logic [9:0]  x_step;
  logic [8:0]  y_step;
  dir_t        dy_step;
  logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic [3:0]  sc_cur, sc_new;

  btn_sync #(.NUM_LANES(4)) u_sync (
    .clk(clk), .rst_n(rst_n),
    .raw({left_up, left_down, right_up, right_down}),
    .sync(btn)
  );

  always_comb begin
    bx_n    = $signed({1'b0, g.ball_x}) + ((g.dx == DIR_NEG) ? -STEP_S : STEP_S);
    by_n    = $signed({2'b00, g.ball_y}) + ((g.dy == DIR_NEG) ? -STEP_S : STEP_S);
    x_step  = bx_n[9:0];
    y_step  = by_n[8:0];
    dy_step = g.dy;
    if (bx_n < 11'sd0)       x_step = 10'd0;
    else if (bx_n > XMAX_S)  x_step = BALL_X_MAX;
    if (by_n <= 11'sd0) begin
      y_step  = 9'd0;
      dy_step = DIR_POS;
    end else if (by_n >= YMAX_S) begin
      y_step  = BALL_Y_MAX;
      dy_step = DIR_NEG;
    end
  end

  always_comb begin
    ovl_l  = (g.ball_y + 9'(BALL_SIZE) > g.pad_l) && (g.ball_y < g.pad_l + 9'(PADDLE_H));
    ovl_r  = (g.ball_y + 9'(BALL_SIZE) > g.pad_r) && (g.ball_y < g.pad_r + 9'(PADDLE_H));
    hit_l  = (g.dx == DIR_NEG) && (g.ball_x <= L_FACE_X) &&
             (g.ball_x + 10'(BALL_SIZE) > 10'(LEFT_PAD_X)) && ovl_l;
    hit_r  = (g.dx == DIR_POS) && (g.ball_x >= R_FACE_X) && (g.ball_x < R_PAD_END) && ovl_r;
    miss_l = (g.dx == DIR_NEG) && (g.ball_x == 10'd0);
    miss_r = (g.dx == DIR_POS) && (g.ball_x == BALL_X_MAX);
    sc_cur = scorer_r ? g.score_r : g.score_l;
    sc_new = (sc_cur >= SCORE_TOP) ? SCORE_TOP : sc_cur + 4'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (frame_tick) state_nxt = g.game_over ? S_OVER : S_PADDLE;
      S_PADDLE: state_nxt = (g.serve_cnt != 6'd0) ? S_SERVE : S_BALL;
      S_SERVE:  state_nxt = S_WAIT;
      S_BALL:   state_nxt = S_HIT;
      S_HIT:    state_nxt = (!hit_l && !hit_r && (miss_l || miss_r)) ? S_SCORE : S_WAIT;
      S_SCORE:  state_nxt = S_WAIT;
      S_OVER:   state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g        <= GAME_INIT;
      scorer_r <= 1'b0;
    end else begin
      case (state)
        S_PADDLE: begin
          g.pad_l <= paddle_next(g.pad_l, btn[3], btn[2]);
          g.pad_r <= paddle_next(g.pad_r, btn[1], btn[0]);
        end
        S_SERVE: begin
          g.serve_cnt <= g.serve_cnt - 6'd1;
          g.serving   <= (g.serve_cnt != 6'd1);
        end
        S_BALL: begin
          g.ball_x <= x_step;
          g.ball_y <= y_step;
          g.dy     <= dy_step;
        end
        S_HIT: begin
          if (hit_l) begin
            g.ball_x <= L_FACE_X;
            g.dx     <= DIR_POS;
          end else if (hit_r) begin
            g.ball_x <= R_FACE_X;
            g.dx     <= DIR_NEG;
          end else if (miss_l) scorer_r <= 1'b1;
          else if (miss_r)     scorer_r <= 1'b0;
        end
        S_SCORE: begin
          if (scorer_r) g.score_r <= sc_new;
          else          g.score_l <= sc_new;
          if (sc_new == SCORE_TOP) g.game_over <= 1'b1;
          else begin
            // Re-serve toward the player who just conceded.
            g.ball_x    <= BALL_X0;
            g.ball_y    <= BALL_Y0;
            g.dx        <= scorer_r ? DIR_NEG : DIR_POS;
            g.serve_cnt <= SERVE_INIT;
            g.serving   <= 1'b1;
          end
        end
        S_OVER: if (|btn) g <= GAME_INIT;
        default: ;
      endcase
    end

  assign paddle_l_y = g.pad_l;
  assign paddle_r_y = g.pad_r;
  assign ball_x     = g.ball_x;
  assign ball_y     = g.ball_y;
  assign score_l    = g.score_l;
  assign score_r    = g.score_r;
  assign serving    = g.serving;
  assign game_over  = g.game_over;
  assign busy       = (state != S_WAIT);
endmodule
